// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined carry adder.
// Holds the default geometry, the slice-width helper and a geometry check.
package pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;

  // Bits rippled by each pipeline stage.
  function automatic int unsigned slice_w(
    input int unsigned width,
    input int unsigned stages
  );
    return width / stages;
  endfunction

  // Geometry is legal when the word splits into equal slices.
  function automatic bit geom_ok(
    input int unsigned width,
    input int unsigned stages
  );
    return (stages != 0) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder, one instance per stage.
// Ports: a, b (SLICE) operands; ci carry in; s (SLICE) sum; co carry out.
module adder_slice
  import pipe_adder_pkg::*;
#(
  parameter int unsigned SLICE = slice_w(DEF_WIDTH, DEF_STAGES)
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (b[i] & c[i])
                  | (a[i] & c[i]);
  end

  assign co = c[SLICE];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Pipelined ripple-carry adder: WIDTH-bit a+b+cin, one SLICE per stage,
// operands skewed in and sums de-skewed out, valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin;
//        out_valid/out_ready, sum, cout; ovf only with PIPE_ADDER_OVF_EN.
module pipelined_carry_adder
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SLICE = slice_w(WIDTH, STAGES);

  if (!geom_ok(WIDTH, STAGES)) begin : g_bad_geom
    $error("WIDTH must be a multiple of STAGES");
  end

  logic adv;

  // Index k is what stage k sees; index k+1 is stage k's register.
  // Operands are only carried while a later stage still needs them.
  logic [WIDTH-1:0] a_st [STAGES];
  logic [WIDTH-1:0] b_st [STAGES];
  logic [WIDTH-1:0] s_st [STAGES+1];
  logic             c_st [STAGES+1];
  logic             v_st [STAGES+1];

  // Whole pipe moves as one: it advances unless a result is stuck.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign a_st[0] = a;
  assign b_st[0] = b;
  assign s_st[0] = '0;
  assign c_st[0] = cin;
  assign v_st[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage

    logic [SLICE-1:0] slc_s;
    logic             slc_co;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .a  (a_st[k][k*SLICE +: SLICE]),
      .b  (b_st[k][k*SLICE +: SLICE]),
      .ci (c_st[k]),
      .s  (slc_s),
      .co (slc_co)
    );

    // Lower slices arrive already summed; drop this slice in.
    always_comb begin
      s_d = s_st[k];
      s_d[k*SLICE +: SLICE] = slc_s;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_st[k];
        c_q <= slc_co;
        s_q <= s_d;
      end
    end

    assign v_st[k+1] = v_q;
    assign c_st[k+1] = c_q;
    assign s_st[k+1] = s_q;

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_st[k];
          b_q <= b_st[k];
        end
      end

      assign a_st[k+1] = a_q;
      assign b_st[k+1] = b_q;
    end

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_d;
      logic ovf_q;

      // Same-sign operands whose sum flips sign.
      assign ovf_d =
        (a_st[k][WIDTH-1] == b_st[k][WIDTH-1]) &&
        (s_d[WIDTH-1] != a_st[k][WIDTH-1]);

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end

      assign ovf = ovf_q;
    end
`endif

  end

  assign out_valid = v_st[STAGES];
  assign cout      = c_st[STAGES];
  assign sum       = s_st[STAGES];

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder (32/4) plus an 8/1 instance.
// Reference sums come from plain wide arithmetic on the operands.
module tb_pipelined_carry_adder;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  logic         in1_valid;
  logic         in1_ready;
  logic [7:0]   a1;
  logic [7:0]   b1;
  logic         cin1;
  logic         out1_valid;
  logic         out1_ready;
  logic [7:0]   sum1;
  logic         cout1;

`ifdef PIPE_ADDER_OVF_EN
  logic         ovf;
  logic         ovf1;
`endif

  always #5 clk = ~clk;

  pipelined_carry_adder #(
    .WIDTH  (W),
    .STAGES (S)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  pipelined_carry_adder #(
    .WIDTH  (8),
    .STAGES (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in1_valid),
    .in_ready  (in1_ready),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .sum       (sum1),
    .cout      (cout1)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           tag;
    bit           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_in  = 0;
  int   n_out = 0;
  int   cyc   = 0;
  bit   free_run = 1'b0;
  bit   rand_bp  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  // Golden model: full-precision unsigned and signed sums.
  function automatic exp_t model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    exp_t        e;
    logic [W:0]  t;
    longint      r;
    longint      lim;
    t   = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    r   = longint'($signed(x)) + longint'($signed(y))
        + longint'(c);
    lim = longint'(1) << (W - 1);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    e.ovf  = (r >= lim) || (r < -lim);
    e.tag  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  // Monitor: compare on every output transfer.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got sum 0x%0h, expected none",
                 sum);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_out++;
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
`ifdef PIPE_ADDER_OVF_EN
        check("ovf", ovf, e.ovf);
`endif
        if (e.lat) check("latency", cyc - e.tag, S);
      end
    end
  end

  // Random backpressure, applied off the driver's time slot.
  initial forever begin
    @(posedge clk);
    #2;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; holds the beat until accepted.
  task automatic send(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    exp_t e;
    in_valid = 1'b1;
    a   = x;
    b   = y;
    cin = c;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e     = model(x, y, c);
        e.tag = cyc;
        e.lat = free_run;
        sb.push_back(e);
        n_in++;
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: got in_ready 0, expected 1");
  endtask

  task automatic send_rand();
    send($urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", sb.size(), 0);
    repeat (S + 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b1;
    in1_valid  = 1'b0;
    a1         = '0;
    b1         = '0;
    cin1       = 1'b0;
    out1_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    check("rst1_out_valid", out1_valid, 0);
    check("rst1_sum", sum1, 0);
    @(posedge clk);
    #1;

    // Carry across every slice, then overflow corners.
    free_run = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    drain();
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1);
    drain();

    // 16 back-to-back beats; latency checked on each.
    repeat (16) send_rand();
    drain();

    // Full pipe, then 5 stalled cycles with input pending.
    free_run = 1'b0;
    repeat (6) send_rand();
    begin
      logic [W-1:0] xa;
      logic [W-1:0] xb;
      logic         xc;
      xa = $urandom;
      xb = $urandom;
      xc = 1'($urandom_range(0, 1));
      a = xa;
      b = xb;
      cin = xc;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_sum_hold", sum, sb[0].sum);
        check("bp_cout_hold", cout, sb[0].cout);
        @(posedge clk);
        #1;
      end
      out_ready = 1'b1;
      send(xa, xb, xc);
    end
    repeat (4) send_rand();
    drain();
    check("bp_in_out", n_out, n_in);

    // Reset during a stall with work in flight.
    free_run = 1'b1;
    repeat (4) send_rand();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    n_in = n_in - sb.size();
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sum", sum, 0);
    check("mid_rst_cout", cout, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end

    // Random traffic with random backpressure.
    free_run = 1'b0;
    rand_bp  = 1'b1;
    repeat (150) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    in_valid  = 1'b0;
    rand_bp   = 1'b0;
    out_ready = 1'b1;
    drain();
    check("final_in_out", n_out, n_in);

    // Single-stage build: registered add, latency 1.
    in1_valid = 1'b1;
    a1   = 8'hAA;
    b1   = 8'h55;
    cin1 = 1'b1;
    @(negedge clk);
    check("s1_in_ready", in1_ready, 1);
    @(posedge clk);
    #1;
    in1_valid = 1'b0;
    @(negedge clk);
    check("s1_out_valid", out1_valid, 1);
    check("s1_sum", sum1, 8'h00);
    check("s1_cout", cout1, 1);
`ifdef PIPE_ADDER_OVF_EN
    check("s1_ovf", ovf1, 0);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    check("s1_bubble", out1_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
